// File: rtl/clk_divider_pkg.sv
// Shared helpers for the integer clock divider: counter width and the phase
// at which the divided output goes high.
package clk_divider_pkg;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : (($clog2(n) < 1) ? 1 : $clog2(n));
   endfunction

   // ceil(n/2): number of low cycles of the rising-edge output flop
   function automatic int high_start(input int n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Modulo-N phase counter with asynchronous clear; exposes both the current
// phase and the value it takes on the next rising edge.
module clk_div_counter
   import clk_divider_pkg::*;
#(
   parameter int N  = 4,
   parameter int CW = cnt_width(N)
) (
   input  logic          clk_in,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output logic [CW-1:0] cnt_next
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   always_comb begin
      cnt_next = cnt + 1'b1;
      if (cnt == LAST) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/clk_divider.sv
// Integer clock divider: clk_out runs at clk_in / N. Optional odd-N 50% duty
// correction is enabled with the macro CLK_DIVIDER_ODD_DUTY50_EN.
module clk_divider
   import clk_divider_pkg::*;
#(
   parameter int N = 4
) (
   input  logic clk_in,
   input  logic rst,
   output logic clk_out
);

   localparam int            CW = cnt_width(N);
   localparam logic [CW-1:0] H  = CW'(high_start(N));

   generate
      if (N < 2) begin : g_bad_n
         $error("clk_divider: N must be at least 2");
      end
   endgenerate

   // The current phase is not needed here; only the look-ahead value drives q_p.
   logic [CW-1:0] cnt_unused;
   logic [CW-1:0] cnt_next;
   logic          q_p;

   clk_div_counter #(
      .N  (N),
      .CW (CW)
   ) u_counter (
      .clk_in   (clk_in),
      .rst      (rst),
      .cnt      (cnt_unused),
      .cnt_next (cnt_next)
   );

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         q_p <= 1'b0;
      end else begin
         q_p <= (cnt_next >= H);
      end
   end

`ifdef CLK_DIVIDER_ODD_DUTY50_EN
   generate
      if ((N % 2) == 1) begin : g_odd_duty
         // Half-cycle delayed copy stretches the high phase by half a period.
         logic q_n;

         always_ff @(negedge clk_in or posedge rst) begin
            if (rst) begin
               q_n <= 1'b0;
            end else begin
               q_n <= q_p;
            end
         end

         assign clk_out = q_p | q_n;
      end else begin : g_even
         assign clk_out = q_p;
      end
   endgenerate
`else
   assign clk_out = q_p;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider at N = 2, 3, 4, 5 sharing one clock and reset.
`timescale 1ns/1ps
module tb_clk_divider;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic out2, out3, out4, out5;

   int tests = 0;
   int fails = 0;

   // Expected clk_out just after rising edge k (bit k-1) following reset release.
   logic [7:0] exp4 = 8'b0110_0110;
   logic [7:0] exp2 = 8'b0101_0101;
   logic [7:0] exp5 = 8'b1000_1100;
   logic [7:0] exp3_mid = 8'b1001_0010;
`ifdef CLK_DIVIDER_ODD_DUTY50_EN
   logic [7:0] exp3 = 8'b1011_0110;
   longint     exp3_min_w = 30;
`else
   logic [7:0] exp3 = 8'b1001_0010;
   longint     exp3_min_w = 20;
`endif

   always #10 clk = ~clk;

   clk_divider #(.N(2)) u_div2 (.clk_in(clk), .rst(rst), .clk_out(out2));
   clk_divider #(.N(3)) u_div3 (.clk_in(clk), .rst(rst), .clk_out(out3));
   clk_divider #(.N(4)) u_div4 (.clk_in(clk), .rst(rst), .clk_out(out4));
   clk_divider #(.N(5)) u_div5 (.clk_in(clk), .rst(rst), .clk_out(out5));

   // Rising-edge statistics for N = 5, cleared whenever reset asserts.
   int     rise5 = 0;
   time    last5 = 0;
   longint gmin5 = 1000000;
   longint gmax5 = 0;
   always @(posedge out5 or posedge rst) begin
      if (rst) begin
         rise5 = 0;
         gmin5 = 1000000;
         gmax5 = 0;
      end else begin
         if (rise5 > 0) begin
            if (longint'($time - last5) < gmin5) gmin5 = longint'($time - last5);
            if (longint'($time - last5) > gmax5) gmax5 = longint'($time - last5);
         end
         last5 = $time;
         rise5 = rise5 + 1;
      end
   end

   // Narrowest level of the N = 3 output between transitions.
   int     seen3 = 0;
   time    last3 = 0;
   longint w3min = 1000000;
   always @(out3 or posedge rst) begin
      if (rst) begin
         seen3 = 0;
         w3min = 1000000;
      end else begin
         if (seen3 != 0 && longint'($time - last3) < w3min) w3min = longint'($time - last3);
         last3 = $time;
         seen3 = 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic check_num(input string tag, input longint obs, input longint expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      check("rst out2", out2, 1'b0);
      check("rst out3", out3, 1'b0);
      check("rst out4", out4, 1'b0);
      check("rst out5", out5, 1'b0);

      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("out4 edge%0d", i + 1), out4, exp4[i]);
         check($sformatf("out2 edge%0d", i + 1), out2, exp2[i]);
         check($sformatf("out3 edge%0d", i + 1), out3, exp3[i]);
         check($sformatf("out5 edge%0d", i + 1), out5, exp5[i]);
         @(negedge clk);
         #1;
         check($sformatf("out3 mid%0d", i + 1), out3, exp3_mid[i]);
      end

      // Asynchronous reset while out4 is high, well away from any clock edge.
      step();
      step();
      check("out4 high before reset", out4, 1'b1);
      #5;
      rst = 1'b1;
      #1;
      check("out4 async clear", out4, 1'b0);
      step();
      check("out4 held in reset", out4, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("out4 restart edge%0d", i + 1), out4, exp4[i]);
         check($sformatf("out2 restart edge%0d", i + 1), out2, exp2[i]);
      end

      // Long run: N = 5 rise count and spacing, N = 3 narrowest level.
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (100) step();
      check_num("out5 rise count", rise5, 20);
      check_num("out5 min gap ns", gmin5, 100);
      check_num("out5 max gap ns", gmax5, 100);
      check_num("out3 min level ns", w3min, exp3_min_w);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
